fifo_wr_arbiter: RTL

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of one `sync_fifo` instance. It grants one requester at a time and drives `w_en`/`data_write` into the FIFO, stalling on `flag_full`. It caps each grant at MAX_BURST accepted words so that no producer can starve the others. It sits between the producer blocks and the FIFO; the FIFO read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and helpers shared by the
// FIFO write arbiter and the read-side scheduler.
`ifndef FIFO_ARB_PKG_SV
`define FIFO_ARB_PKG_SV

// Word idx of a flattened bus of w-bit words.
`define FA_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin winner search over a doubled request
// vector, starting one place above the previous winner.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [LW-1:0] winner_o,
  output logic          valid_o
);

  logic [2*N-1:0] dbl;
  int             pos;

  // Descending scan: the lowest offset above last wins.
  always_comb begin
    dbl      = {req_i, req_i};
    winner_o = '0;
    valid_o  = |req_i;
    pos      = 0;
    for (int k = N; k >= 1; k--) begin
      pos = int'(last_i) + k;
      if (dbl[pos]) winner_o = LW'(pos % N);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of a sync_fifo write
// port, with a per-grant burst cap and full-flag stall.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] data_in,
  input  logic                          flag_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          w_en,
  output logic [FIFO_WIDTH-1:0]         data_write,
  output logic                          busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        win;
  logic                 win_vld;
  logic                 own_req;
  logic                 wen;
  logic [FIFO_WIDTH-1:0] own_data;

  rr_pick #(
    .N  (NUM_REQ),
    .LW (IW)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (win),
    .valid_o  (win_vld)
  );

  // In GRANT, last_q is the owner index.
  always_comb begin
    own_req  = req[last_q];
    own_data = `FA_SLICE(data_in, last_q, FIFO_WIDTH);
    wen      = (state_q == GRANT) && own_req && !flag_full;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (wen) cnt_d = cnt_q + 1'b1;
        if ((wen && cnt_q == LAST_BEAT) || !own_req) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == GRANT);
  assign grant      = grant_q;
  assign w_en       = wen;
  assign ack        = grant_q & {NUM_REQ{wen}};
  assign data_write = busy ? own_data : '0;

endmodule
